// File: rtl/disp_fb_reader_if.sv
// Bus bundle for the framebuffer reader: arbiter read channel plus the pixel stream.
// The reader side uses the master modport; memory/arbiter and display side use slave.
interface disp_fb_reader_if #(
    parameter int AN = 24,
    parameter int DN = 16
);
    logic          arb_req;
    logic          arb_ack;
    logic [AN-1:0] arb_addr;
    logic          arb_wr;
    logic [DN-1:0] arb_rdata;
    logic          arb_rvalid;
    logic [DN-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_sof;
    logic          pix_eol;

    modport master (
        output arb_req, arb_addr, arb_wr, pix_data, pix_valid, pix_sof, pix_eol,
        input  arb_ack, arb_rdata, arb_rvalid, pix_ready
    );

    modport slave (
        input  arb_req, arb_addr, arb_wr, pix_data, pix_valid, pix_sof, pix_eol,
        output arb_ack, arb_rdata, arb_rvalid, pix_ready
    );
endinterface

// File: rtl/disp_fb_reader.sv
// Framebuffer scan-out reader. Issues raster-order reads of one W x H frame from the
// selected buffer, collects returned data in a first-word-fall-through FIFO and streams
// it downstream with sof/eol markers. Outstanding reads plus FIFO occupancy never exceed
// DEPTH, so returned data always has a free FIFO slot.
module disp_fb_reader #(
    parameter int            AN    = 24,
    parameter int            DN    = 16,
    parameter logic [AN-1:0] BASE  = '0,
    parameter logic [AN-1:0] SWAP  = AN'('h40000),
    parameter int            W     = 480,
    parameter int            H     = 272,
    parameter int            DEPTH = 16
) (
    input  logic                   clkSYS,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stat,
    output logic                   done,
    output logic                   busy,
    output logic                   err,
    disp_fb_reader_if.master       bus
);
    localparam int        PW      = $clog2(DEPTH);
    localparam int        CW      = PW + 1;
    localparam logic [9:0] X_LAST = 10'(W - 1);
    localparam logic [8:0] Y_LAST = 9'(H - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic          fetch_en;
    logic          req_q, req_d;
    logic [9:0]    rx_q;
    logic [8:0]    ry_q;
    logic [9:0]    ox_q;
    logic [8:0]    oy_q;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [AN-1:0] base_q;
    logic [AN-1:0] lin;
    logic [DN-1:0] mem [DEPTH];
    logic          err_q, done_q;

    logic start_ok, ack_fire, req_last, stray, push, pop, pix_last, last_acc, credit_ok;

    assign start_ok = start & (state_q == S_IDLE);
    assign ack_fire = req_q & bus.arb_ack;
    assign req_last = (rx_q == X_LAST) & (ry_q == Y_LAST);
    assign stray    = bus.arb_rvalid & (inflight_q == '0);
    assign push     = bus.arb_rvalid & ~stray;
    assign pop      = bus.pix_valid & bus.pix_ready;
    assign pix_last = (ox_q == X_LAST) & (oy_q == Y_LAST);
    assign last_acc = pop & pix_last;

    assign inflight_d = inflight_q + CW'(ack_fire) - CW'(push);
    assign count_d    = count_q + CW'(push) - CW'(pop);
    assign credit_ok  = ({1'b0, inflight_d} + {1'b0, count_d}) < (CW + 1)'(DEPTH);

    assign lin          = AN'(ry_q) * AN'(W) + AN'(rx_q);
    assign bus.arb_addr = base_q | lin;
    assign bus.arb_req  = req_q;
    assign bus.arb_wr   = 1'b0;
    assign bus.pix_valid = (count_q != '0);
    assign bus.pix_data  = mem[rptr_q];
    assign bus.pix_sof   = bus.pix_valid & (ox_q == '0) & (oy_q == '0);
    assign bus.pix_eol   = bus.pix_valid & (ox_q == X_LAST);
    assign err  = err_q;
    assign done = done_q;

    // State register
    always_ff @(posedge clkSYS) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: Idle -> Fetch on start, Fetch -> Drain on last ack, Drain -> Idle on last accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok)            state_d = S_FETCH;
            S_FETCH: if (ack_fire & req_last) state_d = S_DRAIN;
            S_DRAIN: if (last_acc)            state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy     = (state_q != S_IDLE);
        fetch_en = (state_q == S_FETCH);
    end

    // Next request: hold until acked, re-issue back-to-back while the credit allows
    always_comb begin
        req_d = 1'b0;
        if (state_q == S_IDLE)
            req_d = start_ok;
        else if (fetch_en) begin
            if (ack_fire & req_last)   req_d = 1'b0;
            else if (req_q & ~ack_fire) req_d = 1'b1;
            else                        req_d = credit_ok;
        end
    end

    // Control: request/output coordinates, credit counters, FIFO pointers, err and done
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            req_q      <= 1'b0;
            rx_q       <= '0;
            ry_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            req_q      <= req_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            done_q     <= last_acc;
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (start_ok) begin
                rx_q  <= '0;
                ry_q  <= '0;
                ox_q  <= '0;
                oy_q  <= '0;
                err_q <= 1'b0;
            end else begin
                if (stray) err_q <= 1'b1;
                if (ack_fire) begin
                    if (rx_q == X_LAST) begin
                        rx_q <= '0;
                        ry_q <= (ry_q == Y_LAST) ? '0 : ry_q + 9'd1;
                    end else begin
                        rx_q <= rx_q + 10'd1;
                    end
                end
                if (pop) begin
                    if (ox_q == X_LAST) begin
                        ox_q <= '0;
                        oy_q <= (oy_q == Y_LAST) ? '0 : oy_q + 9'd1;
                    end else begin
                        ox_q <= ox_q + 10'd1;
                    end
                end
            end
        end
    end

    // Data: buffer base latched on start, returned pixels written into the FIFO
    always_ff @(posedge clkSYS) begin
        if (start_ok) base_q <= stat ? SWAP : BASE;
        if (push)     mem[wptr_q] <= bus.arb_rdata;
    end
endmodule
